// File: rtl/mac8_signed_pkg.sv
// Shared constants and state type for the mac8_signed signed dot-product engine.
package mac8_signed_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        BUSY  = 1'b1
    } state_t;

endpackage

// File: rtl/mac8_signed_mul.sv
// Combinational 8x8 signed multiplier feeding the product register of mac8_signed.
module mul8s_core
    import mac8_signed_pkg::*;
(
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [PROD_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mac8_signed.sv
// Three-stage signed 8-bit multiply-accumulate with valid/ready handshakes.
// Optional saturating accumulation is enabled by defining MAC8_SAT_EN.
module mac8_signed
    import mac8_signed_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat
);

    state_t                    state;
    logic                      accept;
    logic                      s1_vld, s1_last;
    logic signed [OP_W-1:0]    s1_a, s1_b;
    logic signed [PROD_W-1:0]  prod;
    logic                      s2_vld, s2_last;
    logic signed [PROD_W-1:0]  s2_p;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   next_acc;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    mul8s_core u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

`ifdef MAC8_SAT_EN
    logic signed [ACC_W:0] sum;
    logic                  clamp;
    logic                  sticky;
    logic                  out_sat_r;

    // One guard bit exposes signed overflow; clamp towards the overflow direction.
    always_comb begin
        sum   = (ACC_W+1)'(acc) + (ACC_W+1)'(s2_p);
        clamp = 1'b0;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            clamp    = 1'b1;
            next_acc = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            next_acc = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky    <= 1'b0;
            out_sat_r <= 1'b0;
        end else if (s2_vld) begin
            if (s2_last) begin
                out_sat_r <= sticky | clamp;
                sticky    <= 1'b0;
            end else begin
                sticky    <= sticky | clamp;
            end
        end
    end

    assign out_sat = out_sat_r;
`else
    assign next_acc = acc + ACC_W'(s2_p);
    assign out_sat  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_vld    <= 1'b0;
            s2_last   <= 1'b0;
            s2_p      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_last <= in_last;
            end
            s2_vld  <= s1_vld;
            s2_p    <= prod;
            s2_last <= s1_last;

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            // BUSY blocks new input until handoff, so a fresh result never collides with a held one.
            if (s2_vld) begin
                if (s2_last) begin
                    out_data  <= next_acc;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc       <= next_acc;
                end
            end

            case (state)
                ACCUM: if (accept && in_last) state <= BUSY;
                BUSY:  if (out_valid && out_ready) state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac8_signed.sv
// Directed self-checking bench for mac8_signed (ACC_W=24 and ACC_W=16 instances in lockstep).
module tb_mac8_signed;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_sat;
    logic [23:0] out_data;
    logic        in_ready16, out_valid16, out_sat16;
    logic [15:0] out_data16;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mac8_signed #(.ACC_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    mac8_signed #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid16),
        .out_ready(out_ready), .out_data(out_data16), .out_sat(out_sat16)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int av, input int bv, input logic last);
        in_valid = 1'b1;
        a        = 8'(av);
        b        = 8'(bv);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int unsigned n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid), 0);
        chk({tag, "_drain_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single-element vector and exact latency
        send(3, -4, 1'b1);
        chk("v1_busy", 32'(in_ready), 0);
        chk("v1_lat0", 32'(out_valid), 0);
        tick();
        chk("v1_lat1", 32'(out_valid), 0);
        tick();
        chk("v1_lat2", 32'(out_valid), 1);
        chk("v1_data", $signed(out_data), -12);
        chk("v1_sat", 32'(out_sat), 0);
        chk("v1_data16", $signed(out_data16), -12);
        drain("v1");

        // Extreme operands
        send(-128, -128, 1'b0);
        send(-128, 127, 1'b1);
        wait_out("v2");
        chk("v2_data", $signed(out_data), 128);
        chk("v2_data16", $signed(out_data16), 128);
        drain("v2");

        // 16-bit overflow boundary
        send(-128, -128, 1'b0);
        send(-128, -128, 1'b1);
        wait_out("v3");
        chk("v3_data24", $signed(out_data), 32768);
        chk("v3_sat24", 32'(out_sat), 0);
`ifdef MAC8_SAT_EN
        chk("v3_data16", $signed(out_data16), 32767);
        chk("v3_sat16", 32'(out_sat16), 1);
`else
        chk("v3_data16", $signed(out_data16), -32768);
        chk("v3_sat16", 32'(out_sat16), 0);
`endif
        drain("v3");

        // Sticky flag must not leak into the next vector
        send(2, 3, 1'b1);
        wait_out("v4");
        chk("v4_data", $signed(out_data), 6);
        chk("v4_sat16", 32'(out_sat16), 0);

        // Hold with backpressure; offered pairs in BUSY must be ignored
        in_valid = 1'b1;
        a = 8'd7;
        b = 8'd7;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", $signed(out_data), 6);
        end
        a = 8'd2;
        b = 8'd5;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid", 32'(out_valid), 0);
        chk("hs_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("next_accepted", 32'(in_ready), 0);
        wait_out("v5");
        chk("v5_data", $signed(out_data), 10);
        drain("v5");

        // Back-to-back pairs
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        send(3, 3, 1'b0);
        send(4, 4, 1'b1);
        wait_out("v6");
        chk("v6_data", $signed(out_data), 30);
        drain("v6");

        // Reset mid-vector discards the partial sum
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        rst = 1'b1;
        #2;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_out_data", $signed(out_data), 0);
        chk("mrst_out_sat", 32'(out_sat), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        send(5, 5, 1'b1);
        wait_out("v7");
        chk("v7_data", $signed(out_data), 25);
        drain("v7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
